// File: rtl/clk_switch_ctrl_if.sv
// Clock-switch controller interface.
// Groups the request/edge inputs and the select/status outputs of clk_switch_ctrl.
//   host_edge : 1-cycle pulse marking a host clock edge (clk domain)
//   slow_req  : level, CPU requires the host-speed clock
//   sel_fast  : enable for the high-speed CPU clock source
//   sel_slow  : enable for the host-derived CPU clock source
//   busy      : changeover in progress
//   tmo_err   : sticky, no host edge arrived within the wait budget
interface clk_switch_ctrl_if;
  logic host_edge;
  logic slow_req;
  logic sel_fast;
  logic sel_slow;
  logic busy;
  logic tmo_err;

  // Requester side: drives requests and edges, observes selects and status
  modport master (
    output host_edge, slow_req,
    input  sel_fast, sel_slow, busy, tmo_err
  );

  // Controller side
  modport slave (
    input  host_edge, slow_req,
    output sel_fast, sel_slow, busy, tmo_err
  );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Glitch-free CPU clock source changeover controller.
// Moves between the high-speed clock and the host-derived clock with a dead
// time (both selects low) on every changeover, aligning slow-clock entry and
// exit to host clock edges. Entry gives up after TMO_CYC cycles without a
// host edge and raises a sticky timeout flag.
// Ports:
//   clk    : high-speed clock, the only clock
//   srst_b : synchronous active-low reset
//   bus    : clk_switch_ctrl_if.slave (host_edge, slow_req in;
//            sel_fast, sel_slow, busy, tmo_err out, all registered)
module clk_switch_ctrl #(
  parameter int unsigned DEAD_CYC = 2,   // 1..15
  parameter int unsigned TMO_CYC  = 255  // 1..255
) (
  input logic               clk,
  input logic               srst_b,
  clk_switch_ctrl_if.slave  bus
);

  localparam int unsigned DCNT_W = 4;
  localparam int unsigned WCNT_W = 8;

  // Dead counter is loaded with DEAD_CYC-1 and the state exits when it reads 0,
  // giving exactly DEAD_CYC cycles in the dead state.
  localparam logic [DCNT_W-1:0] DEAD_LOAD = DCNT_W'(DEAD_CYC - 1);
  localparam logic [WCNT_W-1:0] TMO_VAL   = WCNT_W'(TMO_CYC);

  typedef enum logic [2:0] {
    S_FAST    = 3'd0,
    S_DEAD_A  = 3'd1,
    S_WAIT_IN = 3'd2,
    S_SLOW    = 3'd3,
    S_DEAD_B  = 3'd4
  } state_e;

  state_e              state_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [WCNT_W-1:0]   wcnt_d;
  logic                sel_fast_q;
  logic                sel_slow_q;
  logic                busy_q;
  logic                tmo_err_q;

  // Wait counter next value; the timeout compare uses it so the exit happens
  // on the TMO_CYC-th WAIT_IN cycle. It never reaches wrap since TMO_CYC<=255.
  assign wcnt_d = wcnt_q + WCNT_W'(1);

  // Changeover FSM with registered selects and status
  always_ff @(posedge clk) begin
    if (!srst_b) begin
      state_q    <= S_FAST;
      dcnt_q     <= '0;
      wcnt_q     <= '0;
      sel_fast_q <= 1'b1;
      sel_slow_q <= 1'b0;
      busy_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FAST: begin
          if (bus.slow_req) begin
            state_q    <= S_DEAD_A;
            dcnt_q     <= DEAD_LOAD;
            sel_fast_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        S_DEAD_A: begin
          if (dcnt_q == '0) begin
            state_q <= S_WAIT_IN;
            wcnt_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q - DCNT_W'(1);
          end
        end

        // host_edge has priority over an aborting slow_req drop
        S_WAIT_IN: begin
          if (bus.host_edge) begin
            state_q    <= S_SLOW;
            sel_slow_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (!bus.slow_req) begin
            state_q <= S_DEAD_B;
            dcnt_q  <= DEAD_LOAD;
          end else if (wcnt_d == TMO_VAL) begin
            state_q   <= S_DEAD_B;
            dcnt_q    <= DEAD_LOAD;
            wcnt_q    <= wcnt_d;
            tmo_err_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_d;
          end
        end

        // Leave only on a host edge so the current host cycle completes
        S_SLOW: begin
          if (!bus.slow_req && bus.host_edge) begin
            state_q    <= S_DEAD_B;
            dcnt_q     <= DEAD_LOAD;
            sel_slow_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        S_DEAD_B: begin
          if (dcnt_q == '0) begin
            state_q    <= S_FAST;
            sel_fast_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q - DCNT_W'(1);
          end
        end

        default: begin
          state_q    <= S_FAST;
          sel_fast_q <= 1'b1;
          sel_slow_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_fast = sel_fast_q;
  assign bus.sel_slow = sel_slow_q;
  assign bus.busy     = busy_q;
  assign bus.tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed testbench for clk_switch_ctrl (DEAD_CYC=2, TMO_CYC=8).
// Cycle numbering in comments follows the scenario being exercised: inputs set
// in cycle n are sampled at the edge ending cycle n; checks after step() see
// the outputs of the following cycle.
module tb_clk_switch_ctrl;

  localparam int unsigned DEAD = 2;
  localparam int unsigned TMO  = 8;

  logic clk;
  logic srst_b;
  int   n_assert;
  int   n_fail;
  logic mon_en;
  logic rst_prev;
  int   zero_run;
  logic [1:0] prev_sel;

  clk_switch_ctrl_if bus ();

  clk_switch_ctrl #(
    .DEAD_CYC (DEAD),
    .TMO_CYC  (TMO)
  ) dut (
    .clk    (clk),
    .srst_b (srst_b),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic sf, input logic ss,
                         input logic bz, input logic te);
    chk({tag, "_sel_fast"}, bus.sel_fast, sf);
    chk({tag, "_sel_slow"}, bus.sel_slow, ss);
    chk({tag, "_busy"},     bus.busy,     bz);
    chk({tag, "_tmo_err"},  bus.tmo_err,  te);
  endtask

  // Remember whether the last edge was a reset edge (dead time waived there)
  always @(posedge clk) rst_prev <= !srst_b;

  // Select exclusivity and dead-time monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mutex", bus.sel_fast & bus.sel_slow, 1'b0);
      if ((bus.sel_fast | bus.sel_slow) && ({bus.sel_fast, bus.sel_slow} != prev_sel) && !rst_prev)
        chk("dead_time", (zero_run >= int'(DEAD)), 1'b1);
    end
    if (!bus.sel_fast && !bus.sel_slow) zero_run++;
    else zero_run = 0;
    prev_sel = {bus.sel_fast, bus.sel_slow};
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    zero_run = 0;
    prev_sel = 2'b00;
    srst_b   = 1'b0;
    bus.slow_req  = 1'b0;
    bus.host_edge = 1'b0;

    // Reset state
    step(); step();
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    srst_b = 1'b1;
    mon_en = 1'b1;
    step();
    chk_out("idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // host_edge ignored in FAST
    bus.host_edge = 1'b1; step(); bus.host_edge = 1'b0;
    chk_out("fast_edge", 1'b1, 1'b0, 1'b0, 1'b0);

    // Entry: slow_req at cycle 0, host_edge at cycle 6
    bus.slow_req = 1'b1; step();                       // cycle 1
    chk_out("entry_c1", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 2
    chk_out("entry_c2", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); step(); step(); step();                    // cycle 6
    chk_out("entry_c6", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.host_edge = 1'b1; step(); bus.host_edge = 1'b0; // cycle 7
    chk_out("entry_c7", 1'b0, 1'b1, 1'b0, 1'b0);

    // host_edge while slow_req held keeps SLOW
    bus.host_edge = 1'b1; step(); bus.host_edge = 1'b0;
    chk_out("slow_hold", 1'b0, 1'b1, 1'b0, 1'b0);

    // Exit: slow_req falls at cycle 0, host_edge at cycle 4
    bus.slow_req = 1'b0; step();                       // cycle 1
    chk_out("exit_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    step(); step(); step();                            // cycle 4
    chk_out("exit_c4", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.host_edge = 1'b1; step(); bus.host_edge = 1'b0; // cycle 5
    chk_out("exit_c5", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 6
    chk_out("exit_c6", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 7
    chk_out("exit_c7", 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort: slow_req drop in DEAD_A is ignored, then aborts in WAIT_IN
    bus.slow_req = 1'b1; step();                       // cycle 1 DEAD_A
    bus.slow_req = 1'b0; step();                       // cycle 2 DEAD_A
    chk_out("abort_c2", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 3 WAIT_IN
    chk_out("abort_c3", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 4 DEAD_B
    chk_out("abort_c4", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 5 DEAD_B
    chk_out("abort_c5", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 6 FAST
    chk_out("abort_c6", 1'b1, 1'b0, 1'b0, 1'b0);

    // Collision: host_edge together with slow_req drop in WAIT_IN
    bus.slow_req = 1'b1; step(); step(); step();       // cycle 3 WAIT_IN
    bus.slow_req = 1'b0; bus.host_edge = 1'b1;
    step(); bus.host_edge = 1'b0;                      // cycle 4 SLOW
    chk_out("coll_c4", 1'b0, 1'b1, 1'b0, 1'b0);
    step(); step();                                    // cycle 6, no edge yet
    chk_out("coll_c6", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.host_edge = 1'b1; step(); bus.host_edge = 1'b0; // cycle 7 DEAD_B
    chk_out("coll_c7", 1'b0, 1'b0, 1'b1, 1'b0);

    // slow_req raised during DEAD_B is held off until FAST
    bus.slow_req = 1'b1; step();                       // cycle 8 DEAD_B
    chk_out("holdoff_c8", 1'b0, 1'b0, 1'b1, 1'b0);
    step();                                            // cycle 9 FAST
    chk_out("holdoff_c9", 1'b1, 1'b0, 1'b0, 1'b0);
    step();                                            // cycle 10 DEAD_A
    chk_out("holdoff_c10", 1'b0, 1'b0, 1'b1, 1'b0);

    // Timeout: WAIT_IN occupies cycles 12..19, tmo_err visible at cycle 20
    step(); step();                                    // cycle 12
    for (int i = 0; i < int'(TMO); i++) begin
      chk_out("tmo_wait", 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end                                                // cycle 20 DEAD_B
    chk_out("tmo_c20", 1'b0, 1'b0, 1'b1, 1'b1);
    step();                                            // cycle 21 DEAD_B
    chk_out("tmo_c21", 1'b0, 1'b0, 1'b1, 1'b1);
    step();                                            // cycle 22 FAST
    chk_out("tmo_c22", 1'b1, 1'b0, 1'b0, 1'b1);

    // Re-attempt times out again after exactly TMO cycles; tmo_err stays set
    step();                                            // cycle 23 DEAD_A
    chk_out("retry_c23", 1'b0, 1'b0, 1'b1, 1'b1);
    step(); step();                                    // cycle 25 WAIT_IN
    for (int i = 0; i < int'(TMO); i++) begin
      chk_out("retry_wait", 1'b0, 1'b0, 1'b1, 1'b1);
      step();
    end                                                // cycle 33 DEAD_B
    step();                                            // cycle 34 DEAD_B
    chk_out("retry_c34", 1'b0, 1'b0, 1'b1, 1'b1);
    step();                                            // cycle 35 FAST
    chk_out("retry_c35", 1'b1, 1'b0, 1'b0, 1'b1);

    // Enter SLOW, then reset mid-operation
    step(); step(); step();                            // cycle 38 WAIT_IN
    bus.host_edge = 1'b1; step(); bus.host_edge = 1'b0; // cycle 39 SLOW
    chk_out("pre_rst", 1'b0, 1'b1, 1'b0, 1'b1);
    srst_b = 1'b0; step();
    chk_out("rst_slow", 1'b1, 1'b0, 1'b0, 1'b0);
    srst_b = 1'b1; step();                             // slow_req sampled at once
    chk_out("post_rst", 1'b0, 1'b0, 1'b1, 1'b0);

    bus.slow_req = 1'b0;
    step(); step(); step(); step();
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
